mem_fence_sequencer: RTL and testbench
======================================

// Module: mem_fence_sequencer
// PURPOSE
//  Sequences memory-system maintenance for FENCE, FENCE.I and SFENCE.VMA. Drains the LSQ, then in order:
//  write back the L1 d-cache to L2 (updateL2 handshake), flush the i-cache, flush the L1 TLBs and then the L2 TLB.
//  Sits between the commit/flush unit and the memory system; sole driver of its sync/flush control inputs.
// PARAMETERS
//  ASID_LEN      16    width of flush ASID
//  VPN_LEN       27    width of flush virtual page number
//  SETTLE_CYC    2     idle cycles after L2 TLB flush before done (>=1)
//  SYNC_TIMEOUT  4096  max cycles waiting for l2c_update_done_i; 0 disables
// PORTS
//  clk_i               in   1         clock, rising edge
//  rst_i               in   1         asynchronous reset, active-high
//  req_valid_i         in   1         fence request valid
//  req_ready_o         out  1         sequencer accepts request (high only in IDLE)
//  req_op_i            in   2         00 FENCE, 01 FENCE.I, 10 SFENCE.VMA, 11 reserved (treated as FENCE)
//  req_asid_i          in   ASID_LEN  SFENCE rs2 ASID
//  req_asid_v_i        in   1         rs2!=x0
//  req_vpn_i           in   VPN_LEN   SFENCE rs1 VPN
//  req_vpn_v_i         in   1         rs1!=x0
//  abort_i             in   1         pipeline abort; honoured only in DRAIN
//  lsq_idle_i          in   1         LSQ empty, no outstanding d-TLB/d-cache access
//  synch_l1dc_l2c_o    out  1         1-cycle pulse starting d-cache write-back
//  l2c_update_done_i   in   1         write-back complete (1-cycle pulse)
//  icache_flush_o      out  1         1-cycle i-cache flush pulse
//  l1tlb_flush_type_o  out  2         00 none, 01 all, 10 by ASID, 11 by page (page+ASID when asid valid)
//  l2tlb_flush_type_o  out  2         same encoding
//  clr_l1tlb_mshr_o    out  1         1-cycle pulse, with L1 flush
//  clr_l2tlb_mshr_o    out  1         1-cycle pulse, with L2 flush
//  flush_asid_o        out  ASID_LEN  latched ASID, stable from accept to done
//  flush_page_o        out  VPN_LEN   latched VPN, stable from accept to done
//  done_o              out  1         1-cycle completion pulse
//  err_o               out  1         qualifies done_o: sync timeout occurred
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1; every other output 0; latches and counters 0.
//  Accept when req_valid_i&req_ready_o: latch op/asid/vpn/valid bits; next state DRAIN.
//  FSM, one state per cycle minimum:
//   IDLE     -> DRAIN on accept.
//   DRAIN    -> IDLE on abort_i (no pulses, no done; abort beats lsq_idle_i same cycle);
//               else on lsq_idle_i: FENCE/FENCE.I -> DC_SYNC, SFENCE -> TLB_L1.
//   DC_SYNC  synch_l1dc_l2c_o=1 for this single cycle; clear timer -> DC_WAIT.
//   DC_WAIT  on l2c_update_done_i -> FENCE.I: IC_FLUSH, FENCE: DONE. Timer +1 per cycle;
//               timer==SYNC_TIMEOUT-1 without done -> set err, -> DONE. done_i in DC_SYNC cycle is ignored.
//   IC_FLUSH icache_flush_o=1 one cycle -> DONE.
//   TLB_L1   l1tlb_flush_type_o=code, clr_l1tlb_mshr_o=1 one cycle -> TLB_L2.
//   TLB_L2   l2tlb_flush_type_o=code, clr_l2tlb_mshr_o=1 one cycle; load settle cnt=SETTLE_CYC-1 -> SETTLE.
//   SETTLE   cnt==0 -> DONE, else cnt-1.
//   DONE     done_o=1, err_o=err; clear err -> IDLE.
//  Flush code: !asid_v&!vpn_v=01; asid_v&!vpn_v=10; vpn_v=11. flush types are 00 outside TLB_L1/TLB_L2.
//  abort_i outside DRAIN ignored: write-back and TLB flush always complete once started.
//  Latency (lsq idle, done immediate): FENCE accept->done_o = 4 cycles if l2c done arrives first DC_WAIT cycle;
//   SFENCE = 4+SETTLE_CYC cycles.
//  New request is accepted the cycle after done_o (IDLE); no back-to-back accept in DONE.
//  Timer width $clog2(SYNC_TIMEOUT+1); saturates, never wraps. rst_i mid-sequence -> IDLE immediately,
//   all pulses drop asynchronously.
// TESTING
//  FENCE, lsq_idle_i=1, done_i 3 cyc after sync pulse -> one sync pulse, done_o once, err_o=0, no TLB/icache pulses.
//  FENCE.I -> sync pulse, then icache_flush_o exactly 1 cycle after done_i, done_o next cycle.
//  SFENCE asid_v=1 asid=0x5, vpn_v=0 -> l1 type 10 then l2 type 10 on next cycle, both clr pulses,
//   flush_asid_o=0x5 held, done after 2 settle cycles.
//  SFENCE vpn_v=1 vpn=0x1234 with lsq_idle_i low 10 cycles -> no TLB activity until idle; types 11.
//  FENCE, abort_i in DRAIN -> IDLE, no pulses, no done_o; abort in DC_WAIT ignored.
//  SYNC_TIMEOUT=8, done_i never -> done_o with err_o=1 8 cycles after DC_WAIT entry; rst_i mid-DC_WAIT -> all outputs 0.

Source files
------------

// File: rtl/mem_fence_sequencer.sv
// Memory-maintenance sequencer for FENCE / FENCE.I / SFENCE.VMA: drains the LSQ, then
// runs d-cache write-back, i-cache flush or L1/L2 TLB flush, and reports completion.
module mem_fence_sequencer #(
    parameter int ASID_LEN     = 16,
    parameter int VPN_LEN      = 27,
    parameter int SETTLE_CYC   = 2,
    parameter int SYNC_TIMEOUT = 4096
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [ASID_LEN-1:0] req_asid_i,
    input  logic                req_asid_v_i,
    input  logic [VPN_LEN-1:0]  req_vpn_i,
    input  logic                req_vpn_v_i,
    input  logic                abort_i,
    input  logic                lsq_idle_i,
    output logic                synch_l1dc_l2c_o,
    input  logic                l2c_update_done_i,
    output logic                icache_flush_o,
    output logic [1:0]          l1tlb_flush_type_o,
    output logic [1:0]          l2tlb_flush_type_o,
    output logic                clr_l1tlb_mshr_o,
    output logic                clr_l2tlb_mshr_o,
    output logic [ASID_LEN-1:0] flush_asid_o,
    output logic [VPN_LEN-1:0]  flush_page_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int TMR_W = (SYNC_TIMEOUT > 0) ? $clog2(SYNC_TIMEOUT + 1) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (SYNC_TIMEOUT > 0) ? TMR_W'(SYNC_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [1:0] OP_FENCEI = 2'b01;
    localparam logic [1:0] OP_SFENCE = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_DRAIN, S_DC_SYNC, S_DC_WAIT, S_IC_FLUSH,
        S_TLB_L1, S_TLB_L2, S_SETTLE, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q;
    logic                asid_v_q, vpn_v_q;
    logic [ASID_LEN-1:0] asid_q;
    logic [VPN_LEN-1:0]  vpn_q;
    logic [TMR_W-1:0]    timer_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic                accept;
    logic                timeout_hit;
    logic [1:0]          flush_code;

    assign req_ready_o  = (state_q == S_IDLE);
    assign accept       = req_valid_i & req_ready_o;
    assign timeout_hit  = (SYNC_TIMEOUT > 0) && (timer_q == TMR_LAST);
    assign flush_code   = vpn_v_q ? 2'b11 : (asid_v_q ? 2'b10 : 2'b01);
    assign flush_asid_o = asid_q;
    assign flush_page_o = vpn_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // All pulses are decoded from the state register so reset drops them immediately.
    always_comb begin
        state_d            = state_q;
        synch_l1dc_l2c_o   = 1'b0;
        icache_flush_o     = 1'b0;
        l1tlb_flush_type_o = 2'b00;
        l2tlb_flush_type_o = 2'b00;
        clr_l1tlb_mshr_o   = 1'b0;
        clr_l2tlb_mshr_o   = 1'b0;
        done_o             = 1'b0;
        err_o              = 1'b0;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_DRAIN;
            S_DRAIN: begin
                if (abort_i)         state_d = S_IDLE;
                else if (lsq_idle_i) state_d = (op_q == OP_SFENCE) ? S_TLB_L1 : S_DC_SYNC;
            end
            S_DC_SYNC: begin
                synch_l1dc_l2c_o = 1'b1;
                state_d          = S_DC_WAIT;
            end
            S_DC_WAIT: begin
                if (l2c_update_done_i) state_d = (op_q == OP_FENCEI) ? S_IC_FLUSH : S_DONE;
                else if (timeout_hit)  state_d = S_DONE;
            end
            S_IC_FLUSH: begin
                icache_flush_o = 1'b1;
                state_d        = S_DONE;
            end
            S_TLB_L1: begin
                l1tlb_flush_type_o = flush_code;
                clr_l1tlb_mshr_o   = 1'b1;
                state_d            = S_TLB_L2;
            end
            S_TLB_L2: begin
                l2tlb_flush_type_o = flush_code;
                clr_l2tlb_mshr_o   = 1'b1;
                state_d            = S_SETTLE;
            end
            S_SETTLE:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Request latches, write-back timer (saturating) and settle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= 2'b00;
            asid_v_q <= 1'b0;
            vpn_v_q  <= 1'b0;
            asid_q   <= '0;
            vpn_q    <= '0;
            timer_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= req_op_i;
                asid_v_q <= req_asid_v_i;
                vpn_v_q  <= req_vpn_v_i;
                asid_q   <= req_asid_i;
                vpn_q    <= req_vpn_i;
            end
            case (state_q)
                S_DC_SYNC: timer_q <= '0;
                S_DC_WAIT: begin
                    if (timer_q != '1) timer_q <= timer_q + 1'b1;
                    if (!l2c_update_done_i && timeout_hit) err_q <= 1'b1;
                end
                S_TLB_L2:  cnt_q <= CNT_LOAD;
                S_SETTLE:  if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                S_DONE:    err_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fence_sequencer.sv
// Self-checking bench for mem_fence_sequencer: a step-queue model of each request is
// compared against the DUT every cycle, plus hand-computed latency/event checks.
module tb_mem_fence_sequencer;

    localparam int ASID_LEN = 16;
    localparam int VPN_LEN  = 27;
    localparam int SETTLE   = 2;
    localparam int TIMEOUT  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid, req_ready;
    logic [1:0]          req_op;
    logic [ASID_LEN-1:0] req_asid;
    logic                req_asid_v;
    logic [VPN_LEN-1:0]  req_vpn;
    logic                req_vpn_v;
    logic                abort, lsq_idle, l2c_done;
    logic                synch, icache_flush, clr_l1, clr_l2, done, err;
    logic [1:0]          l1_type, l2_type;
    logic [ASID_LEN-1:0] flush_asid;
    logic [VPN_LEN-1:0]  flush_page;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_fence_sequencer #(
        .ASID_LEN(ASID_LEN), .VPN_LEN(VPN_LEN), .SETTLE_CYC(SETTLE), .SYNC_TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_asid_i(req_asid), .req_asid_v_i(req_asid_v),
        .req_vpn_i(req_vpn), .req_vpn_v_i(req_vpn_v),
        .abort_i(abort), .lsq_idle_i(lsq_idle),
        .synch_l1dc_l2c_o(synch), .l2c_update_done_i(l2c_done),
        .icache_flush_o(icache_flush),
        .l1tlb_flush_type_o(l1_type), .l2tlb_flush_type_o(l2_type),
        .clr_l1tlb_mshr_o(clr_l1), .clr_l2tlb_mshr_o(clr_l2),
        .flush_asid_o(flush_asid), .flush_page_o(flush_page),
        .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait budget expired, got no event expected one", name);
    endtask

    // Model: each accepted request becomes a list of steps consumed as the inputs allow.
    typedef enum int {M_DRAIN, M_SYNC, M_WAIT, M_ICF, M_L1, M_L2, M_SETTLE, M_DONE} step_e;
    step_e               steps[$];
    bit                  m_err = 0;
    int                  m_waited = 0;
    logic [1:0]          m_code = 2'b00;
    logic [ASID_LEN-1:0] m_asid = '0;
    logic [VPN_LEN-1:0]  m_vpn = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            steps.delete();
            m_err  = 0;
            m_asid = '0;
            m_vpn  = '0;
            m_code = 2'b00;
        end else if (steps.size() == 0) begin
            if (req_valid) begin
                m_asid = req_asid;
                m_vpn  = req_vpn;
                m_code = req_vpn_v ? 2'b11 : (req_asid_v ? 2'b10 : 2'b01);
                steps.push_back(M_DRAIN);
                if (req_op == 2'b10) begin
                    steps.push_back(M_L1);
                    steps.push_back(M_L2);
                    for (int i = 0; i < SETTLE; i++) steps.push_back(M_SETTLE);
                end else begin
                    steps.push_back(M_SYNC);
                    steps.push_back(M_WAIT);
                    if (req_op == 2'b01) steps.push_back(M_ICF);
                end
                steps.push_back(M_DONE);
            end
        end else begin
            case (steps[0])
                M_DRAIN: begin
                    if (abort) steps.delete();
                    else if (lsq_idle) void'(steps.pop_front());
                end
                M_SYNC: begin
                    m_waited = 0;
                    void'(steps.pop_front());
                end
                M_WAIT: begin
                    m_waited++;
                    if (l2c_done) void'(steps.pop_front());
                    else if (m_waited == TIMEOUT) begin
                        m_err = 1;
                        void'(steps.pop_front());
                        if (steps[0] == M_ICF) void'(steps.pop_front());
                    end
                end
                M_DONE: begin
                    m_err = 0;
                    void'(steps.pop_front());
                end
                default: void'(steps.pop_front());
            endcase
        end
    end

    always @(negedge clk) begin
        logic e_ready, e_sync, e_ic, e_c1, e_c2, e_done, e_err;
        logic [1:0] e_l1, e_l2;
        e_ready = 1; e_sync = 0; e_ic = 0; e_c1 = 0; e_c2 = 0; e_done = 0; e_err = 0;
        e_l1 = 2'b00; e_l2 = 2'b00;
        if (steps.size() != 0) begin
            e_ready = 0;
            case (steps[0])
                M_SYNC: e_sync = 1;
                M_ICF:  e_ic = 1;
                M_L1:   begin e_l1 = m_code; e_c1 = 1; end
                M_L2:   begin e_l2 = m_code; e_c2 = 1; end
                M_DONE: begin e_done = 1; e_err = m_err; end
                default: ;
            endcase
        end
        check_output("req_ready", req_ready, e_ready);
        check_output("synch", synch, e_sync);
        check_output("icache_flush", icache_flush, e_ic);
        check_output("l1_type", l1_type, e_l1);
        check_output("l2_type", l2_type, e_l2);
        check_output("clr_l1", clr_l1, e_c1);
        check_output("clr_l2", clr_l2, e_c2);
        check_output("done", done, e_done);
        check_output("err", err, e_err);
        check_output("flush_asid", flush_asid, m_asid);
        check_output("flush_page", flush_page, m_vpn);
    end

    // Event log used by the hand-computed checks.
    int accept_cyc, sync_cyc, l2done_cyc, ic_cyc, l1_cyc, l2_cyc, done_cyc;
    int sync_count = 0, ic_count = 0, l1_count = 0, done_count = 0;
    logic [1:0] last_l1_type, last_l2_type;
    logic last_err;

    always @(negedge clk) begin
        if (req_valid && req_ready) accept_cyc = cyc;
        if (synch) begin sync_count++; sync_cyc = cyc; end
        if (l2c_done) l2done_cyc = cyc;
        if (icache_flush) begin ic_count++; ic_cyc = cyc; end
        if (clr_l1) begin l1_count++; l1_cyc = cyc; last_l1_type = l1_type; end
        if (clr_l2) begin l2_cyc = cyc; last_l2_type = l2_type; end
        if (done) begin done_count++; done_cyc = cyc; last_err = err; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic [ASID_LEN-1:0] asid,
                                  input logic asid_v, input logic [VPN_LEN-1:0] vpn,
                                  input logic vpn_v);
        req_op = op; req_asid = asid; req_asid_v = asid_v;
        req_vpn = vpn; req_vpn_v = vpn_v; req_valid = 1;
        tick(1);
        req_valid = 0;
    endtask

    task automatic pulse_l2_done();
        l2c_done = 1;
        tick(1);
        l2c_done = 0;
    endtask

    task automatic wait_sync(input string name, input int budget);
        int start;
        bit seen;
        start = sync_count;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (sync_count > start) begin seen = 1; break; end
            tick(1);
        end
        if (!seen) report_timeout(name);
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        bit seen;
        start = done_count;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_count > start) begin seen = 1; break; end
            tick(1);
        end
        if (!seen) report_timeout(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, s0, i0, l0;
        rst = 1; req_valid = 0; req_op = 0; req_asid = 0; req_asid_v = 0;
        req_vpn = 0; req_vpn_v = 0; abort = 0; lsq_idle = 1; l2c_done = 0;
        #12;
        check_output("reset_ready", req_ready, 1);
        check_output("reset_done", done, 0);
        check_output("reset_asid", flush_asid, 0);
        @(posedge clk); #1;
        rst = 0;
        tick(1);

        $display("[TB] FENCE, write-back done 3 cycles after sync");
        d0 = done_count; s0 = sync_count; i0 = ic_count; l0 = l1_count;
        apply_stimulus(2'b00, 16'h0, 0, 27'h0, 0);
        wait_sync("fence_sync", 10);
        tick(2);
        pulse_l2_done();
        wait_done("fence_done", 10);
        check_output("fence_sync_lat", sync_cyc - accept_cyc, 2);
        check_output("fence_done_after_l2", done_cyc - l2done_cyc, 1);
        check_output("fence_sync_count", sync_count - s0, 1);
        check_output("fence_done_count", done_count - d0, 1);
        check_output("fence_no_ic", ic_count - i0, 0);
        check_output("fence_no_tlb", l1_count - l0, 0);
        check_output("fence_err", last_err, 0);

        $display("[TB] reserved op, immediate write-back done");
        apply_stimulus(2'b11, 16'h0, 0, 27'h0, 0);
        wait_sync("rsvd_sync", 10);
        pulse_l2_done();
        wait_done("rsvd_done", 10);
        check_output("fence_min_latency", done_cyc - accept_cyc, 4);

        $display("[TB] FENCE.I");
        apply_stimulus(2'b01, 16'h0, 0, 27'h0, 0);
        wait_sync("fencei_sync", 10);
        tick(2);
        pulse_l2_done();
        wait_done("fencei_done", 10);
        check_output("fencei_ic_after_l2", ic_cyc - l2done_cyc, 1);
        check_output("fencei_done_after_ic", done_cyc - ic_cyc, 1);

        $display("[TB] SFENCE by ASID");
        apply_stimulus(2'b10, 16'h5, 1, 27'h0, 0);
        wait_done("sfence_asid_done", 20);
        check_output("sfence_latency", done_cyc - accept_cyc, 4 + SETTLE);
        check_output("sfence_l1_lat", l1_cyc - accept_cyc, 2);
        check_output("sfence_l2_after_l1", l2_cyc - l1_cyc, 1);
        check_output("sfence_l1_type", last_l1_type, 2'b10);
        check_output("sfence_l2_type", last_l2_type, 2'b10);
        check_output("sfence_asid_held", flush_asid, 16'h5);

        $display("[TB] SFENCE by page with LSQ busy");
        lsq_idle = 0;
        l0 = l1_count;
        apply_stimulus(2'b10, 16'h7, 1, 27'h1234, 1);
        tick(10);
        check_output("sfence_no_tlb_while_busy", l1_count - l0, 0);
        lsq_idle = 1;
        wait_done("sfence_page_done", 20);
        check_output("sfence_page_l1_lat", l1_cyc - accept_cyc, 12);
        check_output("sfence_page_l1_type", last_l1_type, 2'b11);
        check_output("sfence_page_l2_type", last_l2_type, 2'b11);
        check_output("sfence_page_held", flush_page, 27'h1234);

        $display("[TB] abort in DRAIN");
        lsq_idle = 0;
        d0 = done_count; s0 = sync_count;
        apply_stimulus(2'b00, 16'h0, 0, 27'h0, 0);
        tick(2);
        abort = 1;
        lsq_idle = 1;
        tick(1);
        abort = 0;
        tick(3);
        check_output("abort_no_done", done_count - d0, 0);
        check_output("abort_no_sync", sync_count - s0, 0);
        check_output("abort_ready", req_ready, 1);

        $display("[TB] abort in DC_WAIT is ignored");
        d0 = done_count;
        apply_stimulus(2'b00, 16'h0, 0, 27'h0, 0);
        wait_sync("abort_wait_sync", 10);
        tick(1);
        abort = 1;
        tick(1);
        abort = 0;
        pulse_l2_done();
        wait_done("abort_wait_done", 10);
        check_output("abort_wait_done_count", done_count - d0, 1);
        check_output("abort_wait_err", last_err, 0);

        $display("[TB] write-back timeout, done_i only during sync cycle");
        apply_stimulus(2'b01, 16'h0, 0, 27'h0, 0);
        tick(1);
        pulse_l2_done();
        wait_done("timeout_done", 30);
        check_output("timeout_latency", done_cyc - (sync_cyc + 1), TIMEOUT);
        check_output("timeout_err", last_err, 1);

        $display("[TB] reset in DC_WAIT");
        apply_stimulus(2'b00, 16'h0, 0, 27'h0, 0);
        wait_sync("rst_sync", 10);
        tick(2);
        #3 rst = 1;
        #1;
        check_output("rst_sync_low", synch, 0);
        check_output("rst_done_low", done, 0);
        check_output("rst_err_low", err, 0);
        check_output("rst_ready", req_ready, 1);
        check_output("rst_page", flush_page, 0);
        @(posedge clk); #1;
        rst = 0;
        tick(1);
        apply_stimulus(2'b01, 16'h0, 0, 27'h0, 0);
        wait_sync("post_rst_sync", 10);
        pulse_l2_done();
        wait_done("post_rst_done", 10);
        check_output("post_rst_err", last_err, 0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
